// File: rtl/tt_um_emern_triangle_loader_if.sv
// Byte-stream handshake carrying packed vertex data into the triangle loader.
//   in_data  : vertex byte from the source
//   in_valid : in_data is valid this cycle
//   in_ready : loader accepts a byte this cycle (transfer on valid && ready)
// master = byte source, slave = loader.
interface tt_um_emern_triangle_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/tt_um_emern_triangle_loader.sv
// Triangle loader: gathers 9 bytes (3 vertices x 3 bytes) into staging slots,
// rejects out-of-screen triangles, sorts the vertices by x descending (stable)
// and publishes them on the next frame_start so the outputs hold for a frame.
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   in_s (slave)       : byte stream in_data / in_valid / in_ready
//   frame_start        : one-cycle pulse at start of vertical blank
//   v0..v2_x / v0..v2_y: active vertex set, v0 has the largest x
//   tri_valid          : active vertex set is meaningful
//   err                : one-cycle pulse when a triangle is rejected
module tt_um_emern_triangle_loader (
    input  logic       clk,
    input  logic       rst,
    tt_um_emern_triangle_loader_if.slave in_s,
    input  logic       frame_start,
    output logic [9:0] v0_x,
    output logic [8:0] v0_y,
    output logic [9:0] v1_x,
    output logic [8:0] v1_y,
    output logic [9:0] v2_x,
    output logic [8:0] v2_y,
    output logic       tri_valid,
    output logic       err
);
    typedef enum logic [2:0] {LOAD, SORT1, SORT2, SORT3, PENDING} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [9:0] sx [3];
    logic [8:0] sy [3];
    logic [1:0] vk;          // vertex index of the current byte
    logic [1:0] bj;          // byte position within the vertex
    logic       accept;
    logic [8:0] y2_full;
    logic       range_bad;

    assign in_s.in_ready = (state == LOAD) && !rst;
    assign accept        = in_s.in_valid && in_s.in_ready;

    always_comb begin
        vk = 2'd0;
        bj = 2'd0;
        case (cnt)
            4'd0: begin vk = 2'd0; bj = 2'd0; end
            4'd1: begin vk = 2'd0; bj = 2'd1; end
            4'd2: begin vk = 2'd0; bj = 2'd2; end
            4'd3: begin vk = 2'd1; bj = 2'd0; end
            4'd4: begin vk = 2'd1; bj = 2'd1; end
            4'd5: begin vk = 2'd1; bj = 2'd2; end
            4'd6: begin vk = 2'd2; bj = 2'd0; end
            4'd7: begin vk = 2'd2; bj = 2'd1; end
            default: begin vk = 2'd2; bj = 2'd2; end
        endcase
    end

    // Vertex 2's y upper bits arrive with the last byte, so the range check
    // must use the incoming byte rather than the staging slot.
    assign y2_full   = {in_s.in_data[2:0], sy[2][5:0]};
    assign range_bad = (sx[0] > 10'd639) || (sx[1] > 10'd639) || (sx[2] > 10'd639) ||
                       (sy[0] > 9'd479)  || (sy[1] > 9'd479)  || (y2_full > 9'd479);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                sx[i] <= '0;
                sy[i] <= '0;
            end
            v0_x      <= '0;
            v0_y      <= '0;
            v1_x      <= '0;
            v1_y      <= '0;
            v2_x      <= '0;
            v2_y      <= '0;
            tri_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        case (bj)
                            2'd0: sx[vk][7:0] <= in_s.in_data;
                            2'd1: begin
                                sx[vk][9:8] <= in_s.in_data[1:0];
                                sy[vk][5:0] <= in_s.in_data[7:2];
                            end
                            default: sy[vk][8:6] <= in_s.in_data[2:0];
                        endcase
                        if (cnt == 4'd8) begin
                            cnt <= 4'd0;
                            if (range_bad) err   <= 1'b1;
                            else           state <= SORT1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                // Three strict compare-swaps form a stable descending bubble sort.
                SORT1, SORT3: begin
                    if (sx[0] < sx[1]) begin
                        sx[0] <= sx[1];
                        sx[1] <= sx[0];
                        sy[0] <= sy[1];
                        sy[1] <= sy[0];
                    end
                    state <= (state == SORT1) ? SORT2 : PENDING;
                end
                SORT2: begin
                    if (sx[1] < sx[2]) begin
                        sx[1] <= sx[2];
                        sx[2] <= sx[1];
                        sy[1] <= sy[2];
                        sy[2] <= sy[1];
                    end
                    state <= SORT3;
                end
                PENDING: begin
                    if (frame_start) begin
                        v0_x      <= sx[0];
                        v0_y      <= sy[0];
                        v1_x      <= sx[1];
                        v1_y      <= sy[1];
                        v2_x      <= sx[2];
                        v2_y      <= sy[2];
                        tri_valid <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: doc/tt_um_emern_triangle_loader.md
TT_UM_EMERN_TRIANGLE_LOADER -- requirements
Module: tt_um_emern_triangle_loader

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have the port `clk`: input, 1 bit, rising-edge clock.
REQ-003 The block SHALL have the port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have the port `in_data`: input, 8 bits, byte stream of vertex data.
REQ-005 The block SHALL have the port `in_valid`: input, 1 bit, `in_data` is valid.
REQ-006 The block SHALL have the port `in_ready`: output, 1 bit, block accepts a byte this cycle.
REQ-007 The block SHALL have the port `frame_start`: input, 1 bit, one-cycle pulse at the start of the vertical blank.
REQ-008 The block SHALL have the ports `v0_x`, `v1_x`, `v2_x`: outputs, 10 bits each, active vertex columns.
REQ-009 The block SHALL have the ports `v0_y`, `v1_y`, `v2_y`: outputs, 9 bits each, active vertex rows.
REQ-010 The block SHALL have the port `tri_valid`: output, 1 bit, the active vertex set is meaningful.
REQ-011 The block SHALL have the port `err`: output, 1 bit, one-cycle pulse when a triangle is rejected.

Function
REQ-012 Byte transfer: a byte SHALL be accepted only on a cycle with `in_valid` && `in_ready` both high.
REQ-013 Triangle format: 9 bytes SHALL make up one triangle, as 3 bytes per vertex k = 0, 1, 2 in arrival order:
- byte0 = x[7:0];
- byte1 = {y[5:0], x[9:8]};
- byte2 = {5'b0, y[8:6]}.
REQ-014 Reserved bits: byte2[7:3] SHALL be ignored.
REQ-015 States: the block SHALL implement the states LOAD, SORT1, SORT2, SORT3 and PENDING.
REQ-016 LOAD: `in_ready` SHALL be 1 only in LOAD and while `rst` is low.
- A byte counter runs 0..8.
- On acceptance of byte 8, the next state is SORT1 and the counter returns to 0.
REQ-017 Range check on LOAD->SORT1: if any x > 639 or any y > 479, the triangle SHALL be discarded.
- `err` = 1 for exactly the next cycle.
- The state returns to LOAD.
- The active outputs are unchanged.
REQ-018 Sort: SORT1, SORT2 and SORT3 SHALL each take one cycle and perform a compare-swap on the staging slots.
- SORT1 uses slots (0,1), SORT2 uses slots (1,2), SORT3 uses slots (0,1).
- A swap occurs only when the lower slot's x < the higher slot's x, strictly.
- The result is x0 >= x1 >= x2, with equal x keeping arrival order (stable).
- x and y of a vertex move together.
REQ-019 Sort transitions: SORT3 SHALL go to PENDING on the next edge.
- The latency from acceptance of byte 8 to PENDING is 4 clock edges.
REQ-020 PENDING: when `frame_start` = 1, the staging slots SHALL be copied to the v*_x / v*_y outputs on that edge.
- `tri_valid` is set to 1 on the same edge.
- The state returns to LOAD.
- Otherwise the block holds in PENDING with `in_ready` = 0.
REQ-021 `frame_start` in any state other than PENDING SHALL have no effect, including on the same cycle SORT3 completes; the commit waits for the next pulse.
REQ-022 Stability: the outputs SHALL change only on a PENDING commit or on reset, so they stay constant through a frame.
REQ-023 Partial triangle: the byte counter SHALL persist across idle cycles (`in_valid` = 0); no timeout applies.
REQ-024 Pipelining: no byte SHALL be accepted during SORT1..SORT3 or PENDING.
REQ-025 Implementation: the datapath SHALL be plain unsigned comparisons only, with no multipliers.

Reset
REQ-026 While `rst` = 1 on a rising edge, the block SHALL enter LOAD with byte counter = 0.
REQ-027 On that reset edge, the staging slots, all v*_x and v*_y outputs, `tri_valid` and `err` SHALL all become 0.
REQ-028 Reset SHALL have priority over every other input, including `frame_start` in PENDING.
REQ-029 Reset SHALL abort a partially loaded or sorting triangle without commit or `err`.
REQ-030 `in_ready` SHALL be 0 during reset and SHALL be 1 on the first cycle after `rst` falls.

Verification
REQ-031 Scenario "sort": send vertices (100,50), (300,20), (200,400) with `in_valid` held, then pulse `frame_start`.
- Required: `in_ready` = 0 for 4 cycles after byte 8.
- After the pulse: v0 = (300,20), v1 = (200,400), v2 = (100,50), `tri_valid` = 1.
REQ-032 Scenario "tie": send (50,10), (50,20), (10,30).
- Required: v0 = (50,10), v1 = (50,20), v2 = (10,30).
REQ-033 Scenario "reject": send a triangle containing x = 640.
- Required: `err` pulses exactly one cycle.
- The outputs keep the previous triangle and `in_ready` returns to 1.
- Also send y = 480; required: same behaviour.
REQ-034 Scenario "commit gating": pulse `frame_start` on the SORT3 cycle.
- Required: no commit on that pulse.
- The commit happens on the next pulse; `in_ready` stays 0 until it.
REQ-035 Scenario "backpressure/idle": toggle `in_valid` randomly while sending (639,479), (0,0), (320,240).
- Required: v0 = (639,479), v1 = (320,240), v2 = (0,0).
REQ-036 Scenario "reset mid-load": assert `rst` after 5 bytes, then send a full triangle.
- Required: all outputs 0 and `tri_valid` = 0 after reset.
- The new triangle then decodes from byte 0 correctly.
